// File: rtl/data_register_pkg.sv
// -----------------------------------------------------------------------------
// data_register_pkg
// Shared constants for the mainboard architectural registers (e.g. AM).
// Holds the default storage width and the reset/idle words that every
// data_register instance falls back to when it is not overridden.
// Ports: none (package).
// -----------------------------------------------------------------------------
package data_register_pkg;

  // Default datapath word width.
  localparam int DR_WIDTH = 32;

  // Word loaded into storage while reset is asserted.
  localparam logic [31:0] DR_RESET_VALUE = 32'h0000_0000;

  // Word driven onto the internal bus while the output is not enabled.
  localparam logic [31:0] DR_IDLE_VALUE = 32'h0000_0000;

endpackage : data_register_pkg

// File: rtl/data_register.sv
// -----------------------------------------------------------------------------
// data_register
// Single-word storage register for the mainboard datapath. A word is captured
// on a rising clk edge while we is high and is shown on out while oe is high.
// out is never tristated: with oe low it carries IDLE_VALUE, because it
// drives a point-to-point internal bus.
//
// Ports:
//   clk  in   1      system clock, storage updates on the rising edge
//   rst  in   1      asynchronous active-high reset, storage <= RESET_VALUE
//   oe   in   1      output enable, out = stored word when high
//   we   in   1      write enable, sampled on the rising edge of clk
//   in   in   WIDTH  write data
//   out  out  WIDTH  read data, IDLE_VALUE while oe is low
// -----------------------------------------------------------------------------
module data_register
  import data_register_pkg::*;
#(
  parameter int               WIDTH       = DR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DR_RESET_VALUE),
  parameter logic [WIDTH-1:0] IDLE_VALUE  = WIDTH'(DR_IDLE_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             we,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Full-word write only; no byte lanes.
  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = in;
    end
  end

  // Reset wins over a concurrent write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Purely combinational read path: no write-through, so a word written at
  // an edge appears only after that edge.
  always_comb begin
    out = IDLE_VALUE;
    if (oe) begin
      out = q_q;
    end
`ifndef SYNTHESIS
    if (!oe) begin
      a_idle_when_disabled : assert (out == IDLE_VALUE)
        else $error("data_register: out differs from IDLE_VALUE while oe is low");
    end
`endif
  end

`ifndef SYNTHESIS
  // Storage must not move across an edge that had we low and rst low.
  // The previous edge's condition and value are remembered and checked at the
  // following edge; any reset in between disarms the check.
  logic             hold_armed_q;
  logic [WIDTH-1:0] q_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_armed_q <= 1'b0;
      q_prev_q     <= RESET_VALUE;
    end else begin
      if (hold_armed_q) begin
        a_hold_when_no_write : assert (q_q == q_prev_q)
          else $error("data_register: storage changed across an edge with we low");
      end
      hold_armed_q <= !we;
      q_prev_q     <= q_q;
    end
  end
`endif

endmodule : data_register

// File: tb/tb_data_register.sv
module tb_data_register;

  localparam logic [31:0] RV_B   = 32'hDEAD_BEEF;
  localparam logic [31:0] IDLE_B = 32'h0BAD_F00D;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        oe;
  logic        we;
  logic [31:0] din;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_c;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the word each register should currently hold.
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [7:0]  m_c;

  always #5 if (clk_en) clk = ~clk;

  data_register u_a (
    .clk(clk), .rst(rst), .oe(oe), .we(we), .in(din), .out(out_a)
  );

  data_register #(.RESET_VALUE(RV_B), .IDLE_VALUE(IDLE_B)) u_b (
    .clk(clk), .rst(rst), .oe(oe), .we(we), .in(din), .out(out_b)
  );

  data_register #(.WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .oe(oe), .we(we), .in(din[7:0]), .out(out_c)
  );

  typedef struct {
    logic        oe;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm);
    chk({nm, ".a"}, out_a, oe ? m_a : 32'h0);
    chk({nm, ".b"}, out_b, oe ? m_b : IDLE_B);
    chk({nm, ".c"}, {24'h0, out_c}, oe ? {24'h0, m_c} : 32'h0);
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      m_a = 32'h0;
      m_b = RV_B;
      m_c = 8'h0;
    end
    #1;
  endtask

  // One rising edge; the model takes the write if the register should.
  task automatic step();
    @(posedge clk);
    if (!rst && we) begin
      m_a = din;
      m_b = din;
      m_c = din[7:0];
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{oe:1'b1, we:1'b1, din:32'h1111_1111, exp_pre:32'h0,          exp_post:32'h1111_1111};
    vecs[1] = '{oe:1'b1, we:1'b0, din:32'h2222_2222, exp_pre:32'h1111_1111, exp_post:32'h1111_1111};
    vecs[2] = '{oe:1'b0, we:1'b1, din:32'h3333_3333, exp_pre:32'h0,          exp_post:32'h0};
    vecs[3] = '{oe:1'b1, we:1'b0, din:32'h0000_0000, exp_pre:32'h3333_3333, exp_post:32'h3333_3333};
    vecs[4] = '{oe:1'b1, we:1'b1, din:32'hFFFF_FFFF, exp_pre:32'h3333_3333, exp_post:32'hFFFF_FFFF};
    vecs[5] = '{oe:1'b1, we:1'b1, din:32'h0000_0000, exp_pre:32'hFFFF_FFFF, exp_post:32'h0};

    // Reset with no clock running.
    oe  = 1'b0;
    we  = 1'b0;
    din = 32'h0;
    set_rst(1'b1);
    #1;
    chk_all("rst_idle");
    oe = 1'b1;
    #1;
    chk_all("rst_oe");
    chk("rst_b_value", out_b, 32'hDEAD_BEEF);

    // Writes are ignored while reset is held across edges.
    clk_en = 1'b1;
    we  = 1'b1;
    din = 32'h0000_0055;
    step();
    step();
    chk_all("rst_hold_we");
    chk("rst_hold_a", out_a, 32'h0);
    we = 1'b0;
    set_rst(1'b0);

    // Table-driven sequence starting from the reset word.
    for (int i = 0; i < 6; i++) begin
      oe  = vecs[i].oe;
      we  = vecs[i].we;
      din = vecs[i].din;
      #1;
      chk($sformatf("tbl%0d_pre", i), out_a, vecs[i].exp_pre);
      chk_all($sformatf("tbl%0d_pre", i));
      step();
      chk($sformatf("tbl%0d_post", i), out_a, vecs[i].exp_post);
      chk_all($sformatf("tbl%0d_post", i));
    end

    // Write then hold for ten edges with input toggling.
    oe  = 1'b1;
    we  = 1'b1;
    din = 32'h1234_5678;
    step();
    we = 1'b0;
    #1;
    chk("wr_rd", out_a, 32'h1234_5678);
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      step();
      chk($sformatf("hold%0d", i), out_a, 32'h1234_5678);
    end

    // Output gating without a clock edge.
    we  = 1'b1;
    din = 32'hA5A5_A5A5;
    step();
    we = 1'b0;
    oe = 1'b0;
    #1;
    chk("gate_off_a", out_a, 32'h0);
    chk("gate_off_b", out_b, IDLE_B);
    oe = 1'b1;
    #1;
    chk("gate_on_a", out_a, 32'hA5A5_A5A5);
    chk_all("gate_on");

    // Back-to-back writes: old value visible until each edge.
    we  = 1'b1;
    din = 32'h0;
    step();
    for (int i = 1; i <= 3; i++) begin
      din = 32'(i);
      #1;
      chk($sformatf("b2b%0d_pre", i), out_a, 32'(i - 1));
      step();
      chk($sformatf("b2b%0d_post", i), out_a, 32'(i));
    end
    we = 1'b0;

    // Asynchronous reset between edges, held across a write, then released.
    we  = 1'b1;
    din = 32'hCAFE_F00D;
    step();
    we = 1'b0;
    #1;
    chk("async_pre", out_a, 32'hCAFE_F00D);
    #2;
    set_rst(1'b1);
    chk("async_mid_a", out_a, 32'h0);
    chk("async_mid_b", out_b, 32'hDEAD_BEEF);
    we  = 1'b1;
    din = 32'h0000_0055;
    step();
    chk("async_edge_a", out_a, 32'h0);
    chk("async_edge_b", out_b, 32'hDEAD_BEEF);
    set_rst(1'b0);
    chk("async_rel_a", out_a, 32'h0);
    step();
    chk("async_first_wr_a", out_a, 32'h0000_0055);
    chk_all("async_first_wr");
    we = 1'b0;

    // Narrow instance: full 8-bit word, upper input bits dropped.
    we  = 1'b1;
    din = 32'hABCD_EFFF;
    step();
    chk("w8_ff", {24'h0, out_c}, 32'h0000_00FF);
    chk("w8_ff_a", out_a, 32'hABCD_EFFF);
    din = 32'h1234_5600;
    step();
    chk("w8_00", {24'h0, out_c}, 32'h0000_0000);
    we = 1'b0;

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      oe  = 1'($urandom);
      we  = 1'($urandom);
      din = $urandom;
      #1;
      chk_all($sformatf("rnd%0d_pre", i));
      if ($urandom_range(0, 19) == 0) begin
        set_rst(1'b1);
        chk_all($sformatf("rnd%0d_rst", i));
        set_rst(1'b0);
      end
      if ($urandom_range(0, 24) == 0) begin
        set_rst(1'b1);
        step();
        chk_all($sformatf("rnd%0d_rsthold", i));
        set_rst(1'b0);
      end else begin
        step();
        chk_all($sformatf("rnd%0d_post", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_data_register

// File: doc/data_register.md
Name: data_register

Overview:
- General-purpose single-word storage register used as an architectural register on the mainboard datapath (e.g. the AM register).
- Captures a data word on a clocked write strobe and presents the stored word on its output when output-enabled.
- Output is never tristated; the block drives an internal point-to-point bus.

Parameters:
- WIDTH, 32, data width in bits of in, out and the storage element.
- RESET_VALUE, 0, value loaded into storage on reset (WIDTH bits).
- IDLE_VALUE, 0, value driven on out while oe is low (WIDTH bits).

Ports:
- clk  input  1  system clock; storage updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- oe  input  1  output enable; when high, out shows the stored word.
- we  input  1  write enable; sampled on the rising edge of clk.
- in  input  WIDTH  write data.
- out  output  WIDTH  read data, gated by oe.
- Port order is exactly clk, rst, oe, we, in, out; positional instantiation must work.

Behaviour:
- Storage q (WIDTH bits) is internal.
- Reset: rst high forces q = RESET_VALUE immediately, with no clock needed. q holds RESET_VALUE while rst stays high, and we is ignored during that time.
- Reset mid-operation: rst overrides any concurrent write in that cycle. The first write is accepted on the first rising edge after rst deasserts.
- Write: on a rising clk edge with rst low and we = 1, q <= in.
- Hold: with we = 0, q is unchanged indefinitely.
- No partial or byte writes; the full word is always written.
- Read: out is combinational from q and oe.
  - oe = 1: out = q.
  - oe = 0: out = IDLE_VALUE.
- There is no extra read latency beyond the combinational gating.
- Write latency: a value written at edge N is visible on out (with oe = 1) immediately after edge N. There is no write-through. While we = 1 before the edge, out still shows the old q.
- Simultaneous oe = 1 and we = 1: out shows the old q until the edge, then the new q.
- Output during reset: with oe = 1, out = RESET_VALUE. With oe = 0, out = IDLE_VALUE.
- X/undefined inputs on in are stored only when we = 1. oe or we at X is a bench error and is not defined behaviour.
- No internal state machine. The block is a single state element plus an output mux.
- Required assertions (inside translate_off):
  - out == IDLE_VALUE whenever oe == 0.
  - q stable across any edge where we == 0 and rst == 0.

Decomposition:
- Shared package/include: the WIDTH default (32) and the reset and idle constants, alongside the existing control-pin and state defines.
- No sub-module; a single module containing the storage process, the output mux and the assertions.
- Deliverable includes the self-checking bench described below.

Test Plan:
- Reset: rst = 1 with no clock, then oe = 1 -> out = 0x00000000; with RESET_VALUE = 0xDEADBEEF -> out = 0xDEADBEEF.
- Write/read: we = 1, in = 0x12345678 for one edge, then we = 0, oe = 1 -> out = 0x12345678; it holds over 10 further edges with in toggling.
- Output gating: after storing 0xA5A5A5A5, set oe = 0 -> out = 0 (IDLE_VALUE). Set oe = 1 -> out = 0xA5A5A5A5 the same cycle with no clock.
- Back-to-back writes: in = 1, 2, 3 with we = 1 on consecutive edges, oe = 1 -> out = 0, 1, 2, 3 after each edge. The old value is visible before each edge, showing no write-through.
- Async reset mid-operation: q = 0xCAFEF00D, assert rst between edges -> out = RESET_VALUE before the next edge. rst with we = 1 and in = 0x55 across an edge -> q stays RESET_VALUE. First edge after release with we = 1 -> out = 0x55.
- Width: WIDTH = 8, write 0xFF then 0x00 -> out = 0xFF then 0x00 with no truncation or extension errors.
